synch_bin_count_dwn: RTL and testbench

- Synchronous N-bit binary down-counter with count enable.
- Counts down by one on each enabled rising clock edge and wraps from zero to all-ones.
- Used as a generic decrementing tick/sequence source. Also provides a terminal-count/borrow output so that counters can be cascaded.

---
 rtl/synch_bin_count_dwn_if.sv | 24 ++
 rtl/synch_bin_count_dwn.sv | 43 ++++
 tb/tb_synch_bin_count_dwn.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/synch_bin_count_dwn_if.sv
// Count-enable / count-value bundle for the synchronous binary down-counter.
// The master drives the enable; the slave (the counter) returns count and flags.
interface synch_bin_count_dwn_if #(
  parameter int Nbits = 4
);
  logic             ena;
  logic [Nbits-1:0] counter;
  logic             tc;
  logic             zero;

  modport master (
    output ena,
    input  counter,
    input  tc,
    input  zero
  );

  modport slave (
    input  ena,
    output counter,
    output tc,
    output zero
  );
endinterface

// File: rtl/synch_bin_count_dwn.sv
// Nbits-wide binary down-counter with count enable, registered zero flag and a
// combinational borrow (tc) for cascading into the next more-significant stage.
module synch_bin_count_dwn #(
  parameter int          Nbits   = 4,
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic                clk,
  input  logic                rst,
  synch_bin_count_dwn_if.slave bus
);

  localparam logic [Nbits-1:0] RST_CNT = RST_VAL[Nbits-1:0];

  logic [Nbits-1:0] count_p0;
  logic [Nbits-1:0] count_nxt;
  logic [Nbits:0]   borrow;
  logic             zero_p0;

  // Borrow ripples upward through zero bits; a bit flips when a borrow reaches it.
  // The borrow leaving the top bit is exactly ena & (counter == 0).
  assign borrow[0] = bus.ena;

  for (genvar i = 0; i < Nbits; i++) begin : g_bit
    assign count_nxt[i]  = count_p0[i] ^ borrow[i];
    assign borrow[i + 1] = borrow[i] & ~count_p0[i];
  end

  // ---- stage p0: registered count and zero flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_p0 <= RST_CNT;
      zero_p0  <= (RST_CNT == '0);
    end else begin
      count_p0 <= count_nxt;
      zero_p0  <= (count_nxt == '0);
    end
  end

  assign bus.counter = count_p0;
  assign bus.zero    = zero_p0;
  assign bus.tc      = borrow[Nbits] & rst;

endmodule

// File: tb/tb_synch_bin_count_dwn.sv
// Randomised self-checking bench: three counter configurations run side by side
// against an arithmetic reference model (modulo-2^N decrement).
module tb_synch_bin_count_dwn;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  // reference model state: plain integers, decremented modulo 2^N
  int m4;
  int m1;
  int m8;

  localparam int R4 = 0;
  localparam int R1 = 3 % 2;
  localparam int R8 = 3;

  synch_bin_count_dwn_if #(.Nbits(4)) b4 ();
  synch_bin_count_dwn_if #(.Nbits(1)) b1 ();
  synch_bin_count_dwn_if #(.Nbits(8)) b8 ();

  synch_bin_count_dwn #(.Nbits(4), .RST_VAL(32'd0)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  synch_bin_count_dwn #(.Nbits(1), .RST_VAL(32'd3)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  synch_bin_count_dwn #(.Nbits(8), .RST_VAL(32'd3)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cnt4"},  32'(b4.counter), 32'(m4));
    chk({tag, "_zero4"}, 32'(b4.zero),    32'(m4 == 0));
    chk({tag, "_cnt1"},  32'(b1.counter), 32'(m1));
    chk({tag, "_zero1"}, 32'(b1.zero),    32'(m1 == 0));
    chk({tag, "_cnt8"},  32'(b8.counter), 32'(m8));
    chk({tag, "_zero8"}, 32'(b8.zero),    32'(m8 == 0));
  endtask

  // Called just after a falling edge: apply enables, check tc, clock, check state.
  task automatic step(input logic e4, input logic e1, input logic e8, input string tag);
    b4.ena = e4;
    b1.ena = e1;
    b8.ena = e8;
    #1;
    chk({tag, "_tc4"}, 32'(b4.tc), 32'(e4 && m4 == 0));
    chk({tag, "_tc1"}, 32'(b1.tc), 32'(e1 && m1 == 0));
    chk({tag, "_tc8"}, 32'(b8.tc), 32'(e8 && m8 == 0));
    @(posedge clk);
    if (e4) m4 = (m4 + 16 - 1) % 16;
    if (e1) m1 = (m1 + 2 - 1) % 2;
    if (e8) m8 = (m8 + 256 - 1) % 256;
    @(negedge clk);
    chk_state(tag);
  endtask

  // Asynchronous reset pulse between clock edges, with enable held high.
  task automatic async_reset(input string tag);
    b4.ena = 1'b1;
    b1.ena = 1'b1;
    b8.ena = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    m4 = R4;
    m1 = R1;
    m8 = R8;
    chk_state(tag);
    chk({tag, "_tc4"}, 32'(b4.tc), 32'd0);
    chk({tag, "_tc1"}, 32'(b1.tc), 32'd0);
    chk({tag, "_tc8"}, 32'(b8.tc), 32'd0);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    b4.ena  = 1'b0;
    b1.ena  = 1'b0;
    b8.ena  = 1'b0;
    m4 = R4;
    m1 = R1;
    m8 = R8;

    // Reset held across several edges, first with ena low, then high.
    @(negedge clk);
    chk_state("rst_a");
    chk("rst_tc4", 32'(b4.tc), 32'd0);
    b4.ena = 1'b1;
    b1.ena = 1'b1;
    b8.ena = 1'b1;
    @(negedge clk);
    chk_state("rst_b");
    chk("rst_ena_tc4", 32'(b4.tc), 32'd0);
    chk("rst_ena_tc1", 32'(b1.tc), 32'd0);
    chk("rst_ena_tc8", 32'(b8.tc), 32'd0);
    @(negedge clk);
    chk_state("rst_c");
    rst = 1'b1;

    // Basic count, full wrap, then down to 9 for the hold test.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, "basic");
    chk("basic_end4", 32'(b4.counter), 32'd6);
    chk("basic_end8", 32'(b8.counter), 32'd249);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, "wrap");
    for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 1'b1, "to9");
    chk("at9", 32'(b4.counter), 32'd9);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, "hold9");
    chk("hold9_end", 32'(b4.counter), 32'd9);

    // Drive to 0 and hold there: tc must stay low while ena is low.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, "to0");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "hold0");

    // Down to 5, reset mid-count, then the next enabled edge gives all-ones.
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b1, "to5");
    chk("at5", 32'(b4.counter), 32'd5);
    async_reset("midrst");
    step(1'b1, 1'b1, 1'b1, "postrst");
    chk("postrst4", 32'(b4.counter), 32'd15);
    chk("postrst8", 32'(b8.counter), 32'd2);

    // Randomised enables with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset("rnd_rst");
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) != 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
